// File: rtl/robot_pkg.sv
// Shared constants and types for the robot motion-sensing blocks.
package robot_pkg;

  localparam int unsigned POS_WIDTH             = 32;
  localparam int unsigned DEFAULT_SAMPLE_PERIOD = 50000;
  localparam int unsigned DEFAULT_VEL_WIDTH     = 16;

  // Estimator lifecycle: baseline capture, tap fill, steady-state output.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/velocity_average.sv
// Four-tap moving average: shift in one delta per sample, publish the
// floored mean one cycle after the shift.
module velocity_average
  import robot_pkg::*;
#(
  parameter int unsigned VEL_WIDTH = DEFAULT_VEL_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic signed [VEL_WIDTH-1:0] delta,
  input  logic                        shift_en,
  output logic signed [VEL_WIDTH-1:0] average,
  output logic                        done
);

  logic signed [VEL_WIDTH-1:0] taps_q [4];
  logic                        shift_q;
  logic signed [VEL_WIDTH+1:0] sum;

  // Sum of the taps; two guard bits make overflow impossible.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      sum = sum + (VEL_WIDTH + 2)'(taps_q[i]);
    end
  end

  // Tap shift register (newest at index 0) plus the registered average.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        taps_q[i] <= '0;
      end
      shift_q <= 1'b0;
      average <= '0;
      done    <= 1'b0;
    end else begin
      if (shift_en) begin
        taps_q[0] <= delta;
        taps_q[1] <= taps_q[0];
        taps_q[2] <= taps_q[1];
        taps_q[3] <= taps_q[2];
      end
      shift_q <= shift_en;
      done    <= shift_q;
      if (shift_q) begin
        // Arithmetic shift floors toward minus infinity.
        average <= VEL_WIDTH'(sum >>> 2);
      end
    end
  end

endmodule

// File: rtl/velocity_estimator.sv
// Encoder velocity estimator: periodic position sampling, wrap-safe delta,
// saturation to the output width and a four-sample moving average.
module velocity_estimator
  import robot_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = DEFAULT_SAMPLE_PERIOD,
  parameter int unsigned VEL_WIDTH     = DEFAULT_VEL_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [POS_WIDTH-1:0]        io_position,
  output logic signed [VEL_WIDTH-1:0] io_velocity,
  output logic                        io_valid,
  output logic                        io_saturated
);

  localparam int unsigned     CNT_W    = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam longint          VMAX     = (longint'(1) <<< (VEL_WIDTH - 1)) - 1;
  localparam longint          VMIN     = -(longint'(1) <<< (VEL_WIDTH - 1));

  logic [CNT_W-1:0]            cnt_q;
  logic                        tick;
  state_t                      state_q;
  logic [1:0]                  fill_q;
  logic [POS_WIDTH-1:0]        prev_q;
  logic                        sat_q;
  logic                        emit_q;
  logic                        emit2_q;
  logic signed [VEL_WIDTH-1:0] vel_hold_q;

  logic [POS_WIDTH-1:0]        diff;
  logic signed [POS_WIDTH-1:0] raw;
  logic signed [VEL_WIDTH-1:0] sat_delta;
  logic                        clipped;
  logic                        shift_en;
  logic                        eligible;
  logic signed [VEL_WIDTH-1:0] avg;
  logic                        avg_done;

  assign tick = (cnt_q == CNT_LAST);

  // Sample-period counter; tick marks the last cycle of each period.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Modular difference reinterpreted as signed makes counter wrap transparent.
  always_comb begin
    diff      = io_position - prev_q;
    raw       = signed'(diff);
    clipped   = 1'b0;
    sat_delta = raw[VEL_WIDTH-1:0];
    if (longint'(raw) > VMAX) begin
      sat_delta = VEL_WIDTH'(VMAX);
      clipped   = 1'b1;
    end else if (longint'(raw) < VMIN) begin
      sat_delta = VEL_WIDTH'(VMIN);
      clipped   = 1'b1;
    end
  end

  // The baseline tick in IDLE produces no delta; the fourth delta enters RUN.
  assign shift_en = tick && (state_q != IDLE);
  assign eligible = (state_q == RUN) || ((state_q == FILL) && (fill_q == 2'd3));

  // Lifecycle FSM, baseline capture, sticky saturation and valid pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      fill_q  <= 2'd0;
      prev_q  <= '0;
      sat_q   <= 1'b0;
      emit_q  <= 1'b0;
      emit2_q <= 1'b0;
    end else begin
      emit_q  <= tick && eligible;
      emit2_q <= emit_q;
      if (tick) begin
        prev_q <= io_position;
        case (state_q)
          IDLE: begin
            state_q <= FILL;
            fill_q  <= 2'd0;
          end
          FILL: begin
            fill_q <= fill_q + 2'd1;
            if (fill_q == 2'd3) begin
              state_q <= RUN;
            end
          end
          RUN:     state_q <= RUN;
          default: state_q <= IDLE;
        endcase
        if (shift_en && clipped) begin
          sat_q <= 1'b1;
        end
      end
    end
  end

  // Holds the last published velocity between valid pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      vel_hold_q <= '0;
    end else begin
      vel_hold_q <= io_velocity;
    end
  end

  velocity_average #(
    .VEL_WIDTH (VEL_WIDTH)
  ) u_average (
    .clock    (clock),
    .reset    (reset),
    .delta    (sat_delta),
    .shift_en (shift_en),
    .average  (avg),
    .done     (avg_done)
  );

  assign io_valid     = avg_done && emit2_q;
  assign io_velocity  = io_valid ? avg : vel_hold_q;
  assign io_saturated = sat_q;

endmodule

// File: tb/tb_velocity_estimator.sv
// Directed-plus-random bench for velocity_estimator with a sample-level model.
module tb_velocity_estimator;

  localparam int P = 4;
  localparam int W = 16;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [31:0]         io_position = '0;
  logic signed [W-1:0] io_velocity;
  logic                io_valid;
  logic                io_saturated;

  always #5 clock = ~clock;

  velocity_estimator #(
    .SAMPLE_PERIOD (P),
    .VEL_WIDTH     (W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_position  (io_position),
    .io_velocity  (io_velocity),
    .io_valid     (io_valid),
    .io_saturated (io_saturated)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: edges since reset, baseline, delta history.
  longint              g = 0;
  int                  k = 0;
  bit                  base = 0;
  logic [31:0]         prev = '0;
  int                  hist[$];
  bit                  m_sat = 0;
  logic signed [W-1:0] exp_vel = '0;
  bit                  exp_valid = 0;
  bit                  pend = 0;
  longint              due = 0;
  int                  due_val = 0;
  int                  nvalid = 0;
  logic [31:0]         targets[$];

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b (edge %0d)", tag, obs, exp, g);
    end
  endtask

  task automatic chk_vel(input string tag, input logic signed [W-1:0] obs,
                         input logic signed [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, obs, exp, g);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare.
  task automatic step();
    int d;
    int s;
    int a;
    @(posedge clock);
    g++;
    if (reset) begin
      k = 0; base = 0; prev = '0; hist.delete(); m_sat = 0; exp_vel = '0; pend = 0;
    end else begin
      k++;
      if (k % P == 0) begin
        if (!base) begin
          base = 1;
          prev = io_position;
        end else begin
          d    = int'(io_position - prev);
          prev = io_position;
          if (d > 32767) begin
            d = 32767; m_sat = 1;
          end else if (d < -32768) begin
            d = -32768; m_sat = 1;
          end
          hist.push_front(d);
          if (hist.size() > 4) void'(hist.pop_back());
          if (hist.size() == 4) begin
            s = hist.sum();
            a = (s >= 0) ? s / 4 : -((-s + 3) / 4);
            pend = 1; due = g + 1; due_val = a;
          end
        end
      end
    end
    #1;
    exp_valid = pend && (due == g);
    if (exp_valid) begin
      exp_vel = due_val[W-1:0];
      pend    = 0;
    end
    if (io_valid === 1'b1) nvalid++;
    chk_bit("valid", io_valid, exp_valid);
    chk_vel("velocity", io_velocity, exp_vel);
    chk_bit("saturated", io_saturated, m_sat);
  endtask

  // Present each queued target only in a tick cycle; junk elsewhere.
  task automatic run_ticks();
    while (targets.size() > 0) begin
      if ((k + 1) % P == 0) io_position = targets.pop_front();
      else                  io_position = $urandom;
      step();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      io_position = $urandom;
      step();
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) step();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] b;
    logic [31:0] p;

    // Reset state
    do_reset(3);
    chk_bit("reset_valid", io_valid, 1'b0);
    chk_vel("reset_velocity", io_velocity, '0);
    chk_bit("reset_saturated", io_saturated, 1'b0);

    // Constant ramp +10: baseline + 8 deltas -> 5 valid pulses
    nvalid = 0;
    b = $urandom;
    for (int i = 0; i <= 8; i++) targets.push_back(b + 32'(10 * i));
    run_ticks();
    idle(3);
    chk_vel("ramp_velocity", io_velocity, 16'sd10);
    chk_int("ramp_pulses", nvalid, 5);

    // Wrap-around across zero
    do_reset(2);
    for (int i = 0; i <= 6; i++) targets.push_back(32'hFFFF_FFF0 + 32'(8 * i));
    run_ticks();
    idle(3);
    chk_vel("wrap_velocity", io_velocity, 16'sd8);
    chk_bit("wrap_saturated", io_saturated, 1'b0);

    // Negative deltas with floor rounding: -1,-1,-1,-2 -> -2
    do_reset(2);
    b = $urandom;
    targets.push_back(b);
    targets.push_back(b - 32'd1);
    targets.push_back(b - 32'd2);
    targets.push_back(b - 32'd3);
    targets.push_back(b - 32'd5);
    run_ticks();
    idle(3);
    chk_vel("floor_velocity", io_velocity, -16'sd2);

    // Saturating jump, then small deltas; flag stays set
    p = b - 32'd5 + 32'd100000;
    targets.push_back(p);
    for (int i = 1; i <= 3; i++) targets.push_back(p + 32'(i));
    run_ticks();
    idle(3);
    chk_bit("sat_sticky", io_saturated, 1'b1);
    chk_vel("sat_velocity", io_velocity, 16'sd8192);

    // Reset at tick+1 of a RUN sample cancels the pending pulse
    do_reset(2);
    b = $urandom;
    for (int i = 0; i <= 6; i++) targets.push_back(b + 32'(7 * i));
    run_ticks();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_bit("cancel_valid", io_valid, 1'b0);
    chk_vel("cancel_velocity", io_velocity, '0);
    step();
    chk_bit("cancel_valid_t2", io_valid, 1'b0);
    nvalid = 0;
    b = $urandom;
    for (int i = 0; i <= 4; i++) targets.push_back(b + 32'(7 * i));
    run_ticks();
    idle(3);
    chk_int("refill_pulses", nvalid, 1);
    chk_vel("refill_velocity", io_velocity, 16'sd7);

    // Reset asserted in a tick cycle: sample dropped, period restarts
    while ((k + 1) % P != 0) begin
      io_position = $urandom;
      step();
    end
    io_position = $urandom;
    reset = 1'b1;
    step();
    reset = 1'b0;
    b = $urandom;
    for (int i = 0; i <= 5; i++) targets.push_back(b - 32'(3 * i));
    run_ticks();
    idle(3);
    chk_vel("tickreset_velocity", io_velocity, -16'sd3);

    // Random deltas, mostly in range with occasional huge jumps
    do_reset(2);
    p = $urandom;
    targets.push_back(p);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(7, 0) == 0) p = p + $urandom;
      else                           p = p + 32'($urandom_range(4000, 0)) - 32'd2000;
      targets.push_back(p);
    end
    run_ticks();
    idle(4);
    chk_bit("random_saturated", io_saturated, m_sat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
